// File: rtl/p_beid_peripheral_f0_apb_initiator.sv
// APB3 initiator: converts single-beat local register requests into SETUP/ACCESS
// transfers, with PREADY wait states, access timeout and a valid/ready response channel.
module p_beid_peripheral_f0_apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [9:0]  PADDR,
    output logic [31:0] PWDATA,
    output logic [2:0]  PPROT,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam bit       TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic        req_ready_reg, req_ready_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    logic        psel_reg, psel_next;
    logic        penable_reg, penable_next;
    logic        pwrite_reg, pwrite_next;
    logic [9:0]  paddr_reg, paddr_next;
    logic [31:0] pwdata_reg, pwdata_next;
    logic [2:0]  pprot_reg, pprot_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;

    logic timeout_hit;
    assign timeout_hit = TIMEOUT_EN && ((9'(wait_cnt_reg) + 9'd1) == TIMEOUT_LIMIT);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            pprot_reg       <= '0;
            wait_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            req_ready_reg   <= req_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            pprot_reg       <= pprot_next;
            wait_cnt_reg    <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        req_ready_next   = req_ready_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        pprot_next       = pprot_reg;
        wait_cnt_next    = wait_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next     = SETUP;
                    req_ready_next = 1'b0;
                    psel_next      = 1'b1;
                    paddr_next     = req_addr;
                    pwrite_next    = req_write;
                    pwdata_next    = req_wdata;
                    pprot_next     = req_prot;
                    wait_cnt_next  = '0;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
            end
            ACCESS: begin
                // Completion takes priority over a timeout firing in the same cycle.
                if (PREADY) begin
                    state_next       = RESP;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = pwrite_reg ? 32'd0 : PRDATA;
                    rsp_err_next     = PSLVERR;
                    rsp_timeout_next = 1'b0;
                end else if (timeout_hit) begin
                    state_next       = RESP;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = 32'd0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                end else if (wait_cnt_reg != 8'hFF) begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    req_ready_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign PSEL        = psel_reg;
    assign PENABLE     = penable_reg;
    assign PWRITE      = pwrite_reg;
    assign PADDR       = paddr_reg;
    assign PWDATA      = pwdata_reg;
    assign PPROT       = pprot_reg;

endmodule

// File: tb/tb_p_beid_peripheral_f0_apb_initiator.sv
// Bench for the APB initiator: directed scenarios plus randomized transfers checked
// against expected timing and response values derived from the transfer parameters.
module tb_p_beid_peripheral_f0_apb_initiator;

    localparam int T = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    p_beid_peripheral_f0_apb_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PPROT       (PPROT),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // One complete transfer. nwait = PREADY-low ACCESS cycles the slave inserts
    // before answering; hold = cycles the response is back-pressured.
    task automatic xfer(input logic [9:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [2:0] prot, input int nwait, input logic [31:0] rdata_in,
                        input logic slverr_in, input int hold);
        int          alen;
        bit          tmo;
        logic [31:0] exp_rdata;
        logic        exp_err;
        tmo       = (T != 0) && (nwait >= T);
        alen      = tmo ? T : nwait + 1;
        exp_rdata = (tmo || wr) ? 32'd0 : rdata_in;
        exp_err   = tmo || slverr_in;

        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata; req_prot = prot;
        PREADY = 1'b0;
        step();
        // SETUP cycle: scramble the request bus to prove the APB side was latched
        req_valid = 1'b0; req_addr = 10'($urandom); req_wdata = $urandom; req_prot = 3'($urandom);
        req_write = 1'($urandom);
        chk("setup_psel", {31'd0, PSEL}, 32'd1);
        chk("setup_penable", {31'd0, PENABLE}, 32'd0);
        chk("setup_req_ready", {31'd0, req_ready}, 32'd0);
        chk("setup_paddr", {22'd0, PADDR}, {22'd0, addr});
        chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, wr});
        chk("setup_pwdata", PWDATA, wdata);
        chk("setup_pprot", {29'd0, PPROT}, {29'd0, prot});
        step();
        for (int k = 0; k < alen; k++) begin
            chk("access_psel", {31'd0, PSEL}, 32'd1);
            chk("access_penable", {31'd0, PENABLE}, 32'd1);
            chk("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("access_paddr", {22'd0, PADDR}, {22'd0, addr});
            if (k == nwait) begin
                PREADY = 1'b1; PRDATA = rdata_in; PSLVERR = slverr_in;
            end else begin
                PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
            step();
        end
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("resp_rdata", rsp_rdata, exp_rdata);
            chk("resp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            chk("resp_timeout", {31'd0, rsp_timeout}, {31'd0, tmo});
            chk("resp_psel", {30'd0, PSEL, PENABLE}, 32'd0);
            chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
            if (h < hold) begin
                rsp_ready = 1'b0;
                req_valid = 1'($urandom);
                req_addr  = 10'($urandom);
            end else begin
                rsp_ready = 1'b1;
                req_valid = 1'b0;
            end
            step();
        end
        rsp_ready = 1'b0;
        chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("done_req_ready", {31'd0, req_ready}, 32'd1);
        chk("done_psel", {31'd0, PSEL}, 32'd0);
        chk("done_paddr_hold", {22'd0, PADDR}, {22'd0, addr});
        chk("done_pwdata_hold", PWDATA, wdata);
        n_xfer++;
        $display("xfer %0d: %s addr=0x%03h wdata=0x%08h prot=%0d nwait=%0d hold=%0d -> rdata=0x%08h err=%0d timeout=%0d",
                 n_xfer, wr ? "WR" : "RD", addr, wdata, prot, nwait, hold, exp_rdata, exp_err, tmo);
    endtask

    initial begin
        PRESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        req_prot = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_apb_ctl", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
        chk("rst_paddr", {22'd0, PADDR}, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pprot", {29'd0, PPROT}, 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        xfer(10'h002, 1'b1, 32'hDEADBEEF, 3'b001, 0, 32'h0, 1'b0, 0);   // zero-wait write
        xfer(10'h010, 1'b0, 32'h0, 3'b000, 3, 32'h000000A5, 1'b0, 0);   // 3 waits, completion at timeout boundary
        xfer(10'h020, 1'b1, 32'h12345678, 3'b010, 1, 32'h0, 1'b1, 0);   // slave error
        xfer(10'h030, 1'b0, 32'h0, 3'b000, 50, 32'hFFFFFFFF, 1'b0, 0);  // timeout
        xfer(10'h031, 1'b0, 32'h0, 3'b100, 0, 32'hCAFEF00D, 1'b0, 0);   // normal after timeout
        xfer(10'h3FF, 1'b0, 32'h0, 3'b111, 2, 32'h5A5A5A5A, 1'b0, 5);   // backpressure

        // Asynchronous reset in ACCESS
        req_valid = 1'b1; req_addr = 10'h155; req_write = 1'b0; req_prot = 3'b011;
        step();
        req_valid = 1'b0;
        step();
        step();
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_psel", {31'd0, PSEL}, 32'd0);
        chk("arst_penable", {31'd0, PENABLE}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_paddr", {22'd0, PADDR}, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        step();
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_still_idle", {30'd0, PSEL, rsp_valid}, 32'd0);
        $display("xfer aborted by reset: addr=0x155");

        for (int i = 0; i < 40; i++) begin
            xfer(10'($urandom), 1'($urandom), $urandom, 3'($urandom),
                 int'($urandom_range(0, 6)), $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time limit 500000 reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/p_beid_peripheral_f0_apb_initiator.md
# p_beid_peripheral_f0_apb_initiator

APB3 initiator that turns single-beat register requests from a local controller into APB transfers toward a `p_beid_peripheral_f0_timer` port (PSEL/PADDR[11:2]/PENABLE/PWRITE/PWDATA/PPROT out, PRDATA/PREADY/PSLVERR in). It sits between a test or DMA sequencer and one timer instance. It runs the two-phase SETUP/ACCESS protocol, honours PREADY wait states, aborts hung transfers with a programmable timeout, and returns read data and error status on a valid/ready response channel.

## Interface
- TIMEOUT_CYCLES, default 255: maximum ACCESS-phase cycles with PREADY=0 before abort; 0 disables timeout; legal range 0..255.
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset; one clock, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when both high.
- req_addr  in  10  word address, maps to PADDR[11:2].
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_prot  in  3  PPROT value; bit0 = privileged.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when both high.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  10  [11:2].
- PWDATA  out  32; PPROT  out  3.
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered.
- IDLE: req_ready=1. On req_valid: latch addr/write/wdata/prot into PADDR/PWRITE/PWDATA/PPROT, go SETUP.
- SETUP: PSEL=1, PENABLE=0, req_ready=0. Always go ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. Wait counter (8-bit) clears on SETUP entry.
  - PREADY=1: capture PRDATA if read (else 0) and PSLVERR; set rsp_timeout=0; go RESP.
  - PREADY=0 and counter+1 == TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): abort. Set rsp_rdata=0, rsp_err=1, rsp_timeout=1; go RESP.
  - Otherwise increment the counter. It saturates at 255 when timeout is disabled.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1, outputs stable. Go IDLE on rsp_ready.
- PADDR/PWRITE/PWDATA/PPROT hold their last values outside transfers. They never change while PSEL=1.
- One outstanding transfer only. No back-to-back SETUP: an IDLE cycle always separates transfers.
- PRDATA and PSLVERR are ignored except in the ACCESS cycle where PREADY=1.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PPROT=0, wait counter 0.
- Request handshake at edge N gives:
  - PSEL=1 in cycle N+1 (SETUP).
  - PENABLE=1 in cycle N+2.
  - With zero wait states, rsp_valid=1 in cycle N+3.
- Each PREADY=0 cycle adds one cycle of latency.
- Timeout with TIMEOUT_CYCLES=T: ACCESS lasts exactly T cycles, then rsp_valid rises in the next cycle and PSEL falls in that same cycle.
- PREADY=1 on the same cycle the timeout would fire: the completion wins, rsp_timeout=0.
- Holding rsp_ready=0 stalls in RESP indefinitely and blocks new requests (req_ready=0).
- Reset asserted mid-transfer: PSEL/PENABLE drop asynchronously and any pending response is discarded.
- Minimum request-to-request throughput: 4 cycles (IDLE, SETUP, ACCESS, RESP) when rsp_ready is held 1.

## Test plan
- Zero-wait write: req addr=0x002, wdata=0xDEADBEEF, prot=3'b001, PREADY=1. Required:
  - PSEL at N+1, PENABLE at N+2, PADDR=0x002, PWDATA=0xDEADBEEF.
  - rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, then PRDATA=0x0000_00A5. Required: rsp_valid at N+6, rsp_rdata=0x000000A5.
- Slave error: PSLVERR=1 with PREADY=1 on a write. Required: rsp_err=1, rsp_timeout=0.
- Timeout, TIMEOUT_CYCLES=4, PREADY stuck 0. Required:
  - PENABLE high exactly 4 cycles.
  - rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A subsequent transfer completes normally.
- Response backpressure: rsp_ready=0 for 5 cycles. Required: rsp_valid and rsp_rdata held stable, req_ready=0, PSEL=0 throughout; IDLE one cycle after rsp_ready=1.
- Async reset in ACCESS: assert PRESETn=0 mid-transfer. Required: PSEL=0, PENABLE=0, rsp_valid=0 immediately; req_ready=1 after release.
